// File: rtl/game_binary_quiz_n.sv
// Binary quiz: shows an NBITS random target MSB-first on the 7-seg code, then scores one-hot button answers over ROUNDS rounds.
// Latency: value/score/round_idx are registered and change on the edge that changes state; no backpressure, presses outside WAIT/QUIZ are dropped.
module game_binary_quiz_n #(
    parameter int unsigned NBITS          = 3,
    parameter int unsigned ROUNDS         = 5,
    parameter int unsigned SHOW_CYCLES    = 10_000_000,
    parameter int unsigned GAP_CYCLES     = 2_000_000,
    parameter int unsigned RESULT_CYCLES  = 10_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned CNT_W          = 26
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2**NBITS-1:0]   btn,
    input  logic [NBITS-1:0]      rnd,
    output logic [3:0]            value,
    output logic [3:0]            score,
    output logic [3:0]            round_idx,
    output logic                  busy
);
    localparam int unsigned BW   = 2**NBITS;
    localparam int unsigned BI_W = (NBITS > 1) ? $clog2(NBITS) : 1;

    localparam logic [3:0] V_CORRECT = 4'd10;
    localparam logic [3:0] V_ERROR   = 4'd11;
    localparam logic [3:0] V_BLANK   = 4'd12;
    localparam logic [3:0] V_QUERY   = 4'd13;

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_SHOW   = 3'd1,
        S_GAP    = 3'd2,
        S_QUIZ   = 3'd3,
        S_RESULT = 3'd4,
        S_SCORE  = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] counter_q, counter_d;
    logic [NBITS-1:0] target_q, target_d;
    logic [BI_W-1:0]  bit_idx_q, bit_idx_d;
    logic [3:0]       value_q, value_d;
    logic [3:0]       score_q, score_d;
    logic [3:0]       round_q, round_d;
    logic             btn_prev_q;

    logic             any_btn;
    logic             press;
    logic [NBITS-1:0] press_idx;

    assign any_btn = |btn;
    assign press   = any_btn & ~btn_prev_q;

    // Scan from the top so the lowest set button ends up winning.
    always_comb begin
        press_idx = '0;
        for (int k = BW - 1; k >= 0; k--) begin
            if (btn[k]) press_idx = NBITS'(k);
        end
    end

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q + CNT_W'(1);
        target_d  = target_q;
        bit_idx_d = bit_idx_q;
        value_d   = value_q;
        score_d   = score_q;
        round_d   = round_q;
        case (state_q)
            S_WAIT: begin
                counter_d = counter_q;
                value_d   = V_BLANK;
                if (press) begin
                    target_d  = rnd;
                    bit_idx_d = BI_W'(NBITS - 1);
                    score_d   = '0;
                    round_d   = '0;
                    counter_d = '0;
                    value_d   = {3'b000, rnd[NBITS-1]};
                    state_d   = S_SHOW;
                end
            end
            S_SHOW: begin
                if (counter_q == CNT_W'(SHOW_CYCLES - 1)) begin
                    counter_d = '0;
                    if (bit_idx_q == '0) begin
                        value_d = V_QUERY;
                        state_d = S_QUIZ;
                    end else begin
                        value_d = V_BLANK;
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (counter_q == CNT_W'(GAP_CYCLES - 1)) begin
                    counter_d = '0;
                    bit_idx_d = bit_idx_q - BI_W'(1);
                    value_d   = {3'b000, target_q[bit_idx_q - BI_W'(1)]};
                    state_d   = S_SHOW;
                end
            end
            S_QUIZ: begin
                if (press) begin
                    counter_d = '0;
                    state_d   = S_RESULT;
                    if (press_idx == target_q) begin
                        value_d = V_CORRECT;
                        if (score_q < 4'(ROUNDS)) score_d = score_q + 4'd1;
                    end else begin
                        value_d = V_ERROR;
                    end
                end else if (counter_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    counter_d = '0;
                    value_d   = V_ERROR;
                    state_d   = S_RESULT;
                end
            end
            S_RESULT: begin
                if (counter_q == CNT_W'(RESULT_CYCLES - 1)) begin
                    counter_d = '0;
                    if (round_q == 4'(ROUNDS - 1)) begin
                        value_d = score_q;
                        state_d = S_SCORE;
                    end else begin
                        round_d   = round_q + 4'd1;
                        target_d  = rnd;
                        bit_idx_d = BI_W'(NBITS - 1);
                        value_d   = {3'b000, rnd[NBITS-1]};
                        state_d   = S_SHOW;
                    end
                end
            end
            S_SCORE: begin
                value_d = score_q;
                if (counter_q == CNT_W'(RESULT_CYCLES - 1)) begin
                    counter_d = '0;
                    value_d   = V_BLANK;
                    state_d   = S_WAIT;
                end
            end
            default: begin
                counter_d = '0;
                value_d   = V_BLANK;
                state_d   = S_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_WAIT;
            counter_q  <= '0;
            target_q   <= '0;
            bit_idx_q  <= BI_W'(NBITS - 1);
            value_q    <= V_BLANK;
            score_q    <= '0;
            round_q    <= '0;
            btn_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            counter_q  <= counter_d;
            target_q   <= target_d;
            bit_idx_q  <= bit_idx_d;
            value_q    <= value_d;
            score_q    <= score_d;
            round_q    <= round_d;
            btn_prev_q <= any_btn;
        end
    end

    assign value     = value_q;
    assign score     = score_q;
    assign round_idx = round_q;
    assign busy      = (state_q != S_WAIT);
endmodule

// File: doc/game_binary_quiz_n.md
Name: game_binary_quiz_n

Overview:
Parametrised successor of the 2-bit binary quiz game. It shows an NBITS-wide random target one bit at a time, MSB first, on the 7-seg digit code, with a blank gap between bits so repeated bits stay distinguishable. The player answers via a one-hot button vector; answers are edge-detected, and each round has a timeout. A multi-round session keeps a score and displays it at the end. The block sits between the button/RNG front end and the 7-seg decoder.

Parameters:
NBITS, 3, target width in bits; legal 1..3; answer range 0..2**NBITS-1.
ROUNDS, 5, rounds per session; legal 1..9, so the score fits one digit.
SHOW_CYCLES, 10_000_000, cycles each bit is displayed.
GAP_CYCLES, 2_000_000, blank cycles between consecutive bits.
RESULT_CYCLES, 10_000_000, cycles the correct/error code is shown; also the cycles the final score is shown.
TIMEOUT_CYCLES, 50_000_000, maximum cycles in QUIZ before an answer counts as wrong.
CNT_W, 26, delay counter width; must hold the largest *_CYCLES value.

Ports:
clk  in  1  system clock.
reset_n  in  1  asynchronous, active-low reset.
btn  in  2**NBITS  answer buttons, already synchronised; btn[k] means "answer k".
rnd  in  NBITS  free-running random value, sampled only at session/round start.
value  out  4  display code: 0/1 bit, 0..9 score digit, 10 correct, 11 error, 12 blank, 13 '?'.
score  out  4  correct answers in the current session.
round_idx  out  4  current round, 0..ROUNDS-1.
busy  out  1  high in every state except WAIT.

Behaviour:
- Reset (async assert, sync release): state=WAIT, value=12, score=0, round_idx=0, counter=0, target=0, bit_idx=NBITS-1, btn_prev=0.
- Press detection:
  - btn_prev is a register of |btn.
  - A press is the cycle where |btn=1 and btn_prev=0.
  - Pressed index = lowest set bit of btn in that cycle.
  - Holding a button produces exactly one press; further presses need a release first.
- value is registered and updated on the same edge as the state, so it always matches the current state.
- States:
  - WAIT: value=12. On a press: target<=rnd, bit_idx<=NBITS-1, score<=0, round_idx<=0, counter<=0, go to SHOW.
  - SHOW: value=target[bit_idx]. counter counts 0..SHOW_CYCLES-1. At SHOW_CYCLES-1: counter<=0; if bit_idx==0 go to QUIZ, else go to GAP.
  - GAP: value=12. At GAP_CYCLES-1: bit_idx<=bit_idx-1, counter<=0, go to SHOW.
  - QUIZ: value=13.
    - Press in QUIZ: if index==target, score+1 and value=10; otherwise value=11. counter<=0, go to RESULT.
    - If counter reaches TIMEOUT_CYCLES-1 with no press: value=11, counter<=0, go to RESULT.
    - A press and the timeout in the same cycle: the press wins.
  - RESULT: value holds. At RESULT_CYCLES-1:
    - If round_idx==ROUNDS-1: go to SCORE with value=score.
    - Otherwise: round_idx+1, target<=rnd, bit_idx<=NBITS-1, go to SHOW.
  - SCORE: value=score. At RESULT_CYCLES-1: go to WAIT with value=12. score and round_idx keep their values until the next session start.
- Presses outside WAIT and QUIZ are ignored; btn_prev still tracks |btn.
- score saturates at ROUNDS and never wraps.
- An unused state encoding goes to WAIT with value=12.
- Asserting reset_n low mid-session aborts immediately to the reset values.

Test Plan:
Bench parameters for all scenarios: NBITS=2, ROUNDS=2, SHOW=4, GAP=2, RESULT=3, TIMEOUT=20.
- Reset then idle 50 cycles -> value=12, busy=0, score=0, round_idx=0 throughout.
- rnd=2'b10, pulse btn[0] in WAIT -> busy=1; value sequence 1 (4 cycles), 12 (2 cycles), 0 (4 cycles), then 13.
- Round 1 target 2: pulse btn[2] in QUIZ -> value=10 for 3 cycles, score=1. Round 2 target 1: press btn[3] -> value=11. Then SCORE shows value=1 for 3 cycles, then WAIT with value=12.
- Hold btn[1] from WAIT through SHOW into QUIZ without release -> no answer registered; value=13 until timeout at cycle 20, then value=11 and score unchanged.
- In QUIZ, press btn[1] and btn[3] together with target=1 -> index 1 is taken, value=10.
- Drop reset_n during GAP -> on the next cycle value=12, score=0, busy=0; a fresh press starts a new session.
